// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start bit, 7 data bits LSB first, even parity, 1 stop bit.
// Stores each frame on held outputs with parity/framing status and a one-cycle ready pulse.
module rx_serial_7e1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic       tem_dado,
    output logic       recebendo,
    output logic [3:0] db_estado
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        START       = 4'd1,
        DADOS       = 4'd2,
        STOP        = 4'd3,
        ARMAZENA    = 4'd4,
        ESPERA_ALTO = 4'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [TW-1:0]   r_tick;
    logic            w_half;
    logic            w_full;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_stop;

    assign w_rx_s = r_sync2;
    assign w_half = (r_tick == HALF_TICK);
    assign w_full = (r_tick == FULL_TICK);

    // Synchronizer resets to 1 so an idle line is not mistaken for a start bit.
    // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= entrada_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next-state default is assigned first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:        if (!w_rx_s) w_next_state = START;
            START:       if (w_half) w_next_state = w_rx_s ? IDLE : DADOS;
            DADOS:       if (w_full && r_bit == 3'd7) w_next_state = STOP;
            STOP:        if (w_full) w_next_state = ARMAZENA;
            ARMAZENA:    w_next_state = r_stop ? IDLE : ESPERA_ALTO;
            ESPERA_ALTO: if (w_rx_s) w_next_state = IDLE;
            default:     w_next_state = IDLE;
        endcase
    end

    // Tick restarts on every state entry and after each full bit period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_stop  <= 1'b0;
        end else begin
            if (w_next_state != r_state || w_full) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + TW'(1);
            end

            if (r_state == START && w_next_state == DADOS) begin
                r_bit <= 3'd0;
            end else if (r_state == DADOS && w_full) begin
                r_bit <= r_bit + 3'd1;
            end

            if (r_state == DADOS && w_full) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end

            if (r_state == STOP && w_full) begin
                r_stop <= w_rx_s;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dados_ascii <= 7'd0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
            tem_dado    <= 1'b0;
        end else begin
            if (r_state == ARMAZENA) begin
                dados_ascii <= r_shift[6:0];
                paridade_ok <= ~^r_shift;
                erro_stop   <= ~r_stop;
            end
            // A frame landing in the same cycle as limpa keeps the flag set.
            if (r_state == ARMAZENA) begin
                tem_dado <= 1'b1;
            end else if (limpa) begin
                tem_dado <= 1'b0;
            end
        end
    end

    assign pronto    = (r_state == ARMAZENA);
    assign recebendo = (r_state != IDLE);
    assign db_estado = r_state;

endmodule
